// File: rtl/sync_frame_capture.sv
// Deserialises the WIDTH payload bits that follow a detector sync pulse, checks a
// trailing even-parity bit, and hands the word downstream over a double-buffered valid/ready port.
module sync_frame_capture #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             sync_hit,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             parity_err,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             run_par;

    always_comb begin
        shift_next = shift_reg;
        if (LSB_FIRST)
            shift_next = {data, shift_reg[WIDTH-1:1]};
        else
            shift_next = {shift_reg[WIDTH-2:0], data};
    end

    // The output register is the second buffer: a frame completing while it is still
    // occupied and not being accepted is dropped and flagged with a one-cycle overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            run_par     <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (sync_hit) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        run_par <= 1'b0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    run_par   <= run_par ^ data;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(WIDTH - 1))
                        state <= PARITY;
                end
                PARITY: begin
                    state <= IDLE;
                    if (!frame_valid || frame_ready) begin
                        frame_data  <= shift_reg;
                        parity_err  <= run_par ^ data;
                        frame_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sync_frame_capture.md
Name: sync_frame_capture

Overview:
- Sits directly downstream of the serial sync-code detector.
- Consumes the detector's one-cycle sync pulse and the same serial bit stream, then deserialises the WIDTH payload bits that follow the sync code.
- Checks a trailing even-parity bit and presents the captured word on a valid/ready interface to the next stage.
- Capture and output are double-buffered: a new frame can be shifted in while the previous word waits for the consumer.

Parameters:
WIDTH, 8, payload bits per frame (legal range 2..32).
LSB_FIRST, 1, 1 = first payload bit received goes to frame_data[0]; 0 = first bit goes to frame_data[WIDTH-1].

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
data  input  1  serial bit stream, one bit per clk, same stream the detector sees.
sync_hit  input  1  one-cycle pulse from the detector marking end of sync code.
frame_data  output  WIDTH  captured payload word, registered; stable while frame_valid=1.
frame_valid  output  1  frame_data/parity_err hold a word not yet accepted.
frame_ready  input  1  consumer accepts the word on any edge where frame_valid=1 and frame_ready=1.
parity_err  output  1  qualifier for frame_data: 1 = received parity bit did not give even parity over payload+parity.
overflow  output  1  one-cycle pulse: a completed frame was dropped because the output buffer was full.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift register=0, frame_data=0, frame_valid=0, parity_err=0, overflow=0. Any partial frame is discarded; release resumes in IDLE.
- FSM states: IDLE, SHIFT, PARITY.
- IDLE: when sync_hit=1 at an edge, go to SHIFT with counter=0. data in the sync_hit cycle is not payload.
- SHIFT: each edge, shift data into the shift register per LSB_FIRST, XOR into the running parity, and increment the counter. After the WIDTH-th bit (counter=WIDTH-1), go to PARITY.
- PARITY: the edge samples the parity bit. Result is err = (running XOR) ^ data. Then go to IDLE and present the frame to the output stage.
- sync_hit while in SHIFT or PARITY is ignored; there is no restart mid-frame.
- Timing: sync_hit high in cycle c0; payload sampled in cycles c1..cWIDTH; parity sampled in cWIDTH+1.
- Latency: frame_valid first high in cycle cWIDTH+2. Frame period is WIDTH+2 cycles minimum, so back-to-back frames are legal when the next sync_hit arrives in cWIDTH+2 or later.
- Output stage, on the edge that ends a PARITY cycle:
  - If frame_valid=0, or frame_valid=1 and frame_ready=1: load frame_data and parity_err; frame_valid=1 (stays 1 across a simultaneous accept+load); overflow=0.
  - If frame_valid=1 and frame_ready=0: new frame dropped; frame_data, parity_err and frame_valid are unchanged; overflow=1 for exactly one cycle.
- Accept with no new frame: frame_valid=1 and frame_ready=1 clears frame_valid next cycle. frame_data retains its last value; parity_err retains its value.
- frame_ready while frame_valid=0 has no effect.
- frame_data and parity_err change only on load or reset.
- overflow is 0 in every cycle other than the drop pulse.

Test Plan:
- Reset, then WIDTH=8, LSB_FIRST=1, frame_ready=1: sync_hit pulse, payload 1,0,1,1,0,0,1,0, parity 0 -> frame_valid high exactly 10 cycles after the sync cycle with frame_data=0x4D, parity_err=0; valid drops the next cycle.
- Same frame with parity bit 1 -> frame_data=0x4D, parity_err=1. With LSB_FIRST=0 and parity 0 -> frame_data=0xB2, parity_err=0.
- frame_ready=0: send frames A=0x4D then B=0x12 back-to-back -> frame_data stays 0x4D with valid=1; overflow pulses once at B's completion. Raise ready -> 0x4D accepted, valid=0, no 0x12 ever appears.
- Simultaneous: valid=1 holding 0x4D, ready asserted exactly on the edge that completes 0x12 -> frame_data=0x12, frame_valid stays 1, overflow=0.
- Extra sync_hit pulses mid-payload -> ignored, frame captured correctly. Assert rst in cycle c4 of a frame -> all outputs 0 immediately; after release, no frame appears until a new sync_hit.
